alu_reg_unit: RTL and testbench
===============================

// Module: alu_reg_unit
// PURPOSE
//  32-bit datapath ALU with a registered result stage (Register32-style load-enabled output register).
//  Sits between the register-file read ports (A = RS data, B = mux1 output) and the writeback/MAR/nextPC paths.
//  Performs arithmetic, logic, shift, compare and optional multiply/divide, and reports condition flags to the control unit.
// PARAMETERS
//  WIDTH   32  datapath width; the behaviour below is defined for 32 only.
// PORTS
//  Clk         in   1   rising-edge clock
//  reset       in   1   synchronous, active-high; clears all registered outputs
//  en          in   1   load enable; when 0 all outputs hold their values
//  operation   in   4   ALU opcode (from the control unit)
//  sign        in   2   bit0: 1 = signed, 0 = unsigned; bit1 is reserved and ignored
//  cmpsignal   in   4   compare condition used by the CMP opcode
//  A           in   32  operand A (RS)
//  B           in   32  operand B (mux1 output)
//  Y           out  32  main result (registered)
//  HI          out  32  mult high word / div remainder (registered)
//  LO          out  32  mult low word / div quotient (registered)
//  carryFlags  out  4   [0]=C, [1]=Z, [2]=N, [3]=V (registered)
// BEHAVIOUR
//  - All outputs update on the rising edge of Clk. Latency is 1 cycle from the inputs to the outputs.
//  - Priority: reset beats en. When reset=1, Y, HI, LO and carryFlags all become 0.
//  - Opcodes:
//      0000 ADD   Y = A + B
//      0001 SUB   Y = A - B
//      0010 AND   0011 OR   0100 XOR   0101 NOR
//      0110 SLL   Y = B << A[4:0]
//      0111 SRL   Y = B >> A[4:0]
//      1000 SRA   Y = B >>> A[4:0]
//      1001 SLT   Y = 1 if A < B, compared signed or unsigned according to sign[0]; otherwise Y = 0
//      1010 MULT  {HI,LO} = A * B (signed per sign[0]); Y = product low word
//      1011 DIV   LO = A / B, HI = A % B; quotient truncates toward zero; Y = quotient
//      1100 LUI   Y = {B[15:0], 16'h0}
//      1101 PASSA Y = A
//      1110 PASSB Y = B
//      1111 CMP   Y = 32'd1 if the cmpsignal condition holds, else 32'd0
//  - cmpsignal values (signedness per sign[0]):
//      0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE
//      6 A<0, 7 A>=0, 8 A<=0, 9 A>0 (always signed tests)
//      10-15 are false
//  - HI and LO are written only by MULT and DIV; every other opcode leaves them unchanged.
//  - Flags are computed for every opcode, from Y:
//      Z = (Y == 0); N = Y[31]
//      C = carry out for ADD, NOT borrow for SUB, 0 for all other opcodes
//      V = signed overflow for ADD/SUB when sign[0]=1, 0 when sign[0]=0; V is also set by DIV by zero
//  - DIV with B = 0: LO = Y = 32'hFFFF_FFFF, HI = A, V = 1.
//  - Signed DIV of 32'h8000_0000 by -1: LO = 32'h8000_0000, HI = 0, V = 1.
//  - Shift amounts use only A[4:0]; a shift of 0 passes B through unchanged.
// CONFIGURATION
//  ALU_MULDIV_EN defined:   MULT and DIV are implemented as described above.
//  ALU_MULDIV_EN undefined: opcodes 1010 and 1011 give Y = 0 with flags computed from that Y.
//                           HI and LO are tied to 0 (still cleared by reset). No multiplier or divider is synthesised.
// TESTING
//  - reset=1 for one edge, with any inputs applied -> Y=0, HI=0, LO=0, carryFlags=0 after that edge.
//  - ADD with A=32'hFFFF_FFFF, B=1, sign=01, en=1 -> next cycle Y=0, C=1, Z=1, N=0, V=0.
//  - SUB with A=32'h7FFF_FFFF, B=32'hFFFF_FFFF, sign=01 -> Y=32'h8000_0000, V=1, N=1.
//  - CMP LT with A=-1, B=1: sign=01 -> Y=1; sign=00 -> Y=0.
//  - MULT with A=-2, B=3, sign=01 (ALU_MULDIV_EN) -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
//    Then ADD with en=0 -> all outputs held.
//  - DIV with A=7, B=0 -> LO=32'hFFFF_FFFF, HI=7, V=1.
//    Then SRA with A=4, B=32'h8000_0000 -> Y=32'hF800_0000, HI/LO unchanged.

Source files
------------

// File: rtl/alu_reg_unit.sv
// 32-bit ALU with a load-enabled registered result stage (Y, HI, LO, flags).
// Optional multiply/divide is built only when ALU_MULDIV_EN is defined.
module alu_reg_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             en,
   input  logic [3:0]       operation,
   input  logic [1:0]       sign,
   input  logic [3:0]       cmpsignal,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [3:0]       carryFlags
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND   = 4'b0010, OP_OR    = 4'b0011,
      OP_XOR  = 4'b0100, OP_NOR  = 4'b0101, OP_SLL   = 4'b0110, OP_SRL   = 4'b0111,
      OP_SRA  = 4'b1000, OP_SLT  = 4'b1001, OP_MULT  = 4'b1010, OP_DIV   = 4'b1011,
      OP_LUI  = 4'b1100, OP_PASSA = 4'b1101, OP_PASSB = 4'b1110, OP_CMP = 4'b1111
   } op_e;

   typedef enum logic [3:0] {
      CMP_EQ = 4'd0, CMP_NE = 4'd1, CMP_LT = 4'd2, CMP_LE = 4'd3, CMP_GT = 4'd4,
      CMP_GE = 4'd5, CMP_ANEG = 4'd6, CMP_ANNEG = 4'd7, CMP_ANPOS = 4'd8, CMP_APOS = 4'd9
   } cmp_e;

   op_e              op;
   logic             is_signed;
   logic             unused_sign_hi;
   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic             add_ovf;
   logic             sub_ovf;
   logic             a_lt_b;
   logic             a_eq_b;
   logic             a_zero;
   logic             cmp_true;
   logic [WIDTH-1:0] y_next;
   logic [WIDTH-1:0] hi_next;
   logic [WIDTH-1:0] lo_next;
   logic             c_next;
   logic             v_next;

   assign op             = op_e'(operation);
   assign is_signed      = sign[0];
   assign unused_sign_hi = sign[1];

   // SUB is formed as A + ~B + 1 so the carry out is directly the NOT-borrow flag.
   assign add_full = {1'b0, A} + {1'b0, B};
   assign sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
   assign add_ovf  = is_signed & (A[WIDTH-1] == B[WIDTH-1]) & (add_full[WIDTH-1] != A[WIDTH-1]);
   assign sub_ovf  = is_signed & (A[WIDTH-1] != B[WIDTH-1]) & (sub_full[WIDTH-1] != A[WIDTH-1]);

   assign a_lt_b = is_signed ? ($signed(A) < $signed(B)) : (A < B);
   assign a_eq_b = (A == B);
   assign a_zero = (A == '0);

   always_comb begin
      cmp_true = 1'b0;
      case (cmp_e'(cmpsignal))
         CMP_EQ:    cmp_true = a_eq_b;
         CMP_NE:    cmp_true = !a_eq_b;
         CMP_LT:    cmp_true = a_lt_b;
         CMP_LE:    cmp_true = a_lt_b | a_eq_b;
         CMP_GT:    cmp_true = !(a_lt_b | a_eq_b);
         CMP_GE:    cmp_true = !a_lt_b;
         CMP_ANEG:  cmp_true = A[WIDTH-1];
         CMP_ANNEG: cmp_true = !A[WIDTH-1];
         CMP_ANPOS: cmp_true = A[WIDTH-1] | a_zero;
         CMP_APOS:  cmp_true = !A[WIDTH-1] & !a_zero;
         default:   cmp_true = 1'b0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   logic [2*WIDTH-1:0] mul_full;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic               div_zero;
   logic               div_ovf;

   assign mul_full = {{WIDTH{is_signed & A[WIDTH-1]}}, A} * {{WIDTH{is_signed & B[WIDTH-1]}}, B};

   // Signed division runs on magnitudes; the most-negative / -1 case falls out as 0x8000_0000 naturally.
   assign a_neg    = is_signed & A[WIDTH-1];
   assign b_neg    = is_signed & B[WIDTH-1];
   assign a_mag    = a_neg ? -A : A;
   assign b_mag    = b_neg ? -B : B;
   assign q_mag    = a_mag / b_mag;
   assign r_mag    = a_mag % b_mag;
   assign quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign rem      = a_neg ? -r_mag : r_mag;
   assign div_zero = (B == '0);
   assign div_ovf  = is_signed & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == '1);
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      y_next  = '0;
      hi_next = HI;
      lo_next = LO;
      c_next  = 1'b0;
      v_next  = 1'b0;
      case (op)
         OP_ADD: begin
            y_next = add_full[WIDTH-1:0];
            c_next = add_full[WIDTH];
            v_next = add_ovf;
         end
         OP_SUB: begin
            y_next = sub_full[WIDTH-1:0];
            c_next = sub_full[WIDTH];
            v_next = sub_ovf;
         end
         OP_AND:   y_next = A & B;
         OP_OR:    y_next = A | B;
         OP_XOR:   y_next = A ^ B;
         OP_NOR:   y_next = ~(A | B);
         OP_SLL:   y_next = B << A[4:0];
         OP_SRL:   y_next = B >> A[4:0];
         OP_SRA:   y_next = $unsigned($signed(B) >>> A[4:0]);
         OP_SLT:   y_next = {{(WIDTH-1){1'b0}}, a_lt_b};
`ifdef ALU_MULDIV_EN
         OP_MULT: begin
            hi_next = mul_full[2*WIDTH-1:WIDTH];
            lo_next = mul_full[WIDTH-1:0];
            y_next  = mul_full[WIDTH-1:0];
         end
         OP_DIV: begin
            if (div_zero) begin
               y_next  = '1;
               lo_next = '1;
               hi_next = A;
               v_next  = 1'b1;
            end else begin
               y_next  = quot;
               lo_next = quot;
               hi_next = rem;
               v_next  = div_ovf;
            end
         end
`else
         OP_MULT:  y_next = '0;
         OP_DIV:   y_next = '0;
`endif
         OP_LUI:   y_next = {B[15:0], {(WIDTH-16){1'b0}}};
         OP_PASSA: y_next = A;
         OP_PASSB: y_next = B;
         OP_CMP:   y_next = {{(WIDTH-1){1'b0}}, cmp_true};
         default:  y_next = '0;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all outputs update together on the edge.
   always_ff @(posedge Clk) begin
      if (reset) begin
         Y          <= '0;
         HI         <= '0;
         LO         <= '0;
         carryFlags <= '0;
      end else if (en) begin
         Y          <= y_next;
         HI         <= hi_next;
         LO         <= lo_next;
         carryFlags <= {v_next, y_next[WIDTH-1], (y_next == '0), c_next};
      end
   end

endmodule

// File: tb/tb_alu_reg_unit.sv
// Randomized self-checking bench for alu_reg_unit against an arithmetic reference model.
// Honors ALU_MULDIV_EN the same way the design does.
module tb_alu_reg_unit;

   logic        Clk = 1'b0;
   logic        reset;
   logic        en;
   logic [3:0]  operation;
   logic [1:0]  sign;
   logic [3:0]  cmpsignal;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] Y;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [3:0]  carryFlags;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] m_y;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [3:0]  m_f;

   always #5 Clk = ~Clk;

   alu_reg_unit dut (
      .Clk        (Clk),
      .reset      (reset),
      .en         (en),
      .operation  (operation),
      .sign       (sign),
      .cmpsignal  (cmpsignal),
      .A          (A),
      .B          (B),
      .Y          (Y),
      .HI         (HI),
      .LO         (LO),
      .carryFlags (carryFlags)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   function automatic logic signed_ovf(input longint r);
      return (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endfunction

   task automatic model_step(input logic rst, input logic e, input logic [3:0] op, input logic [1:0] sg,
                             input logic [3:0] cs, input logic [31:0] a, input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint          xa;
      longint          xb;
      longint          r64;
      longint unsigned ua;
      longint unsigned ub;
      logic [63:0]     p;
      logic [31:0]     y;
      logic            c;
      logic            v;
      logic            s;
      logic            t;
      if (rst) begin
         m_y = '0; m_hi = '0; m_lo = '0; m_f = '0;
         return;
      end
      if (!e) return;
      s  = sg[0];
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      xa = s ? sa : longint'(ua);
      xb = s ? sb : longint'(ub);
      y  = '0;
      c  = 1'b0;
      v  = 1'b0;
      case (op)
         4'd0: begin
            p = ua + ub;
            y = p[31:0];
            c = p[32];
            v = s && signed_ovf(sa + sb);
         end
         4'd1: begin
            y = a - b;
            c = (a >= b);
            v = s && signed_ovf(sa - sb);
         end
         4'd2:  y = a & b;
         4'd3:  y = a | b;
         4'd4:  y = a ^ b;
         4'd5:  y = ~(a | b);
         4'd6:  y = b << a[4:0];
         4'd7:  y = b >> a[4:0];
         4'd8:  y = 32'($signed(b) >>> a[4:0]);
         4'd9:  y = (xa < xb) ? 32'd1 : 32'd0;
         4'd10: begin
`ifdef ALU_MULDIV_EN
            if (s) begin
               r64 = sa * sb;
               p   = r64;
            end else begin
               p = ua * ub;
            end
            m_hi = p[63:32];
            m_lo = p[31:0];
            y    = m_lo;
`endif
         end
         4'd11: begin
`ifdef ALU_MULDIV_EN
            if (b == 32'h0) begin
               m_lo = 32'hFFFF_FFFF;
               m_hi = a;
               v    = 1'b1;
            end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               m_lo = 32'h8000_0000;
               m_hi = 32'h0;
               v    = 1'b1;
            end else if (s) begin
               m_lo = 32'(sa / sb);
               m_hi = 32'(sa % sb);
            end else begin
               m_lo = 32'(ua / ub);
               m_hi = 32'(ua % ub);
            end
            y = m_lo;
`endif
         end
         4'd12: y = {b[15:0], 16'h0};
         4'd13: y = a;
         4'd14: y = b;
         default: begin
            case (cs)
               4'd0:    t = (xa == xb);
               4'd1:    t = (xa != xb);
               4'd2:    t = (xa < xb);
               4'd3:    t = (xa <= xb);
               4'd4:    t = (xa > xb);
               4'd5:    t = (xa >= xb);
               4'd6:    t = (sa < 0);
               4'd7:    t = (sa >= 0);
               4'd8:    t = (sa <= 0);
               4'd9:    t = (sa > 0);
               default: t = 1'b0;
            endcase
            y = t ? 32'd1 : 32'd0;
         end
      endcase
      m_y = y;
      m_f = {v, y[31], (y == 32'h0), c};
   endtask

   task automatic drive(input string tag, input logic rst, input logic e, input logic [3:0] op,
                        input logic [1:0] sg, input logic [3:0] cs, input logic [31:0] a, input logic [31:0] b);
      @(negedge Clk);
      reset     = rst;
      en        = e;
      operation = op;
      sign      = sg;
      cmpsignal = cs;
      A         = a;
      B         = b;
      @(posedge Clk);
      model_step(rst, e, op, sg, cs, a, b);
      #1;
      check({tag, "_y"},  Y,  m_y);
      check({tag, "_hi"}, HI, m_hi);
      check({tag, "_lo"}, LO, m_lo);
      check({tag, "_fl"}, {28'h0, carryFlags}, {28'h0, m_f});
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h1;
         5:       return 32'($urandom_range(0, 31));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      m_y = '0; m_hi = '0; m_lo = '0; m_f = '0;
      reset = 1'b1; en = 1'b1; operation = '0; sign = '0; cmpsignal = '0; A = '0; B = '0;

      drive("rst", 1'b1, 1'b1, 4'd10, 2'b01, 4'd0, 32'hDEAD_BEEF, 32'h1234_5678);
      check("rst_y_zero", Y, 32'h0);
      check("rst_fl_zero", {28'h0, carryFlags}, 32'h0);

      drive("add_wrap", 1'b0, 1'b1, 4'd0, 2'b01, 4'd0, 32'hFFFF_FFFF, 32'h1);
      check("add_wrap_y", Y, 32'h0);
      check("add_wrap_flags", {28'h0, carryFlags}, 32'h3);

      drive("sub_ovf", 1'b0, 1'b1, 4'd1, 2'b01, 4'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      check("sub_ovf_y", Y, 32'h8000_0000);
      check("sub_ovf_flags", {28'h0, carryFlags}, 32'hC);

      drive("cmp_lt_s", 1'b0, 1'b1, 4'd15, 2'b01, 4'd2, 32'hFFFF_FFFF, 32'h1);
      check("cmp_lt_s_lit", Y, 32'h1);
      drive("cmp_lt_u", 1'b0, 1'b1, 4'd15, 2'b00, 4'd2, 32'hFFFF_FFFF, 32'h1);
      check("cmp_lt_u_lit", Y, 32'h0);

      drive("mult", 1'b0, 1'b1, 4'd10, 2'b01, 4'd0, 32'hFFFF_FFFE, 32'h3);
      drive("hold", 1'b0, 1'b0, 4'd0, 2'b01, 4'd0, 32'h1111_1111, 32'h2222_2222);

      drive("div0", 1'b0, 1'b1, 4'd11, 2'b00, 4'd0, 32'h7, 32'h0);
      drive("sra", 1'b0, 1'b1, 4'd8, 2'b00, 4'd0, 32'h4, 32'h8000_0000);
      check("sra_lit", Y, 32'hF800_0000);
      drive("sll0", 1'b0, 1'b1, 4'd6, 2'b00, 4'd0, 32'hFFFF_FFE0, 32'hA5A5_0F0F);
      drive("div_ovf", 1'b0, 1'b1, 4'd11, 2'b01, 4'd0, 32'h8000_0000, 32'hFFFF_FFFF);
      drive("div_neg", 1'b0, 1'b1, 4'd11, 2'b01, 4'd0, 32'hFFFF_FFF9, 32'h2);
      drive("rst_mid", 1'b1, 1'b0, 4'd0, 2'b00, 4'd0, 32'h5, 32'h6);

      for (int i = 0; i < 600; i++) begin
         drive("rnd", ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               pick(), pick());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
